array_allocator: RTL and testbench

ARRAY_ALLOCATOR -- requirements
Module: array_allocator

---
 rtl/array_allocator_pkg.sv | 24 ++
 rtl/array_allocator_if.sv | 15 +
 rtl/array_allocator_rr_arbiter.sv | 29 ++
 rtl/array_allocator.sv | 189 ++++++++++++++++++
 tb/tb_array_allocator.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/array_allocator_pkg.sv
// Shared definitions for the array allocator: parameter defaults, FSM states and op encoding.
package array_allocator_pkg;

  localparam int unsigned MEM_ELEMENT_WIDTH_DEF = 12;
  localparam int unsigned N_ARRAYS_DEF          = 20;
  localparam int unsigned N_REQ_DEF             = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_ALLOC = 1'b0,
    OP_FREE  = 1'b1
  } op_e;

  // Index width for n entries, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/array_allocator_if.sv
// Requester-side handshake bundle: per-requester request/op/id in, shared completion out.
interface array_allocator_if #(
  parameter int unsigned NReq               = 4,
  parameter int unsigned MemoryElementWidth = 12
);
  logic [NReq-1:0]                    req;
  logic [NReq-1:0]                    op;
  logic [NReq*MemoryElementWidth-1:0] freeId;
  logic [NReq-1:0]                    ack;
  logic [MemoryElementWidth-1:0]      ackId;
  logic                               error;

  modport master (output req, op, freeId, input ack, ackId, error);
  modport slave  (input req, op, freeId, output ack, ackId, error);
endinterface

// File: rtl/array_allocator_rr_arbiter.sv
// Round-robin requester selection starting the search at index ptr.
module rr_arbiter
  import array_allocator_pkg::*;
#(
  parameter int unsigned NReq = N_REQ_DEF,
  parameter int unsigned PtrW = idx_w(NReq)
) (
  input  logic [NReq-1:0] req,
  input  logic [PtrW-1:0] ptr,
  output logic [NReq-1:0] grant_c,
  output logic [PtrW-1:0] winner_c
);

  logic found;

  always_comb begin : rr_search
    grant_c  = '0;
    winner_c = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NReq; i++) begin
      if (!found && req[PtrW'((32'(ptr) + i) % NReq)]) begin
        found    = 1'b1;
        winner_c = PtrW'((32'(ptr) + i) % NReq);
      end
    end
    if (found) grant_c[winner_c] = 1'b1;
  end

endmodule

// File: rtl/array_allocator.sv
// Heap array id allocator: serves one alloc/free request per IDLE-EXEC-DONE pass,
// reusing freed ids LIFO before issuing fresh ones.
module array_allocator
  import array_allocator_pkg::*;
#(
  parameter int unsigned MemoryElementWidth = MEM_ELEMENT_WIDTH_DEF,
  parameter int unsigned NArrays            = N_ARRAYS_DEF,
  parameter int unsigned NReq               = N_REQ_DEF
) (
  input  logic                          clock,
  input  logic                          reset,
  array_allocator_if.slave              bus,
  output logic                          sizeWe,
  output logic [MemoryElementWidth-1:0] sizeAddr,
  output logic [MemoryElementWidth-1:0] allocs,
  output logic [MemoryElementWidth-1:0] freedTop,
  output logic                          busy
);

  localparam int unsigned MW   = MemoryElementWidth;
  localparam int unsigned IdxW = idx_w(NArrays);
  localparam int unsigned PtrW = idx_w(NReq);

  state_e          state_q, state_d;
  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0] winner_q, winner_d;
  logic [NReq-1:0] grant_q, grant_d;
  op_e             op_q, op_d;
  logic [MW-1:0]   id_q, id_d;
  logic            err_q, err_d;
  logic            from_stack_q, from_stack_d;
  logic [MW-1:0]   allocs_q, allocs_d;
  logic [MW-1:0]   freed_top_q, freed_top_d;
  logic [NArrays-1:0] in_use_q, in_use_d;
  logic [MW-1:0]   stack_q [NArrays];
  logic [MW-1:0]   stack_d [NArrays];
  logic [NReq-1:0] ack_q, ack_d;
  logic [MW-1:0]   ack_id_q, ack_id_d;
  logic            error_q, error_d;
  logic            size_we_q, size_we_d;
  logic [MW-1:0]   size_addr_q, size_addr_d;
  logic            busy_q, busy_d;

  logic [NReq-1:0] grant_c;
  logic [PtrW-1:0] winner_c;
  op_e             req_op_c;
  logic [MW-1:0]   req_id_c;

  rr_arbiter #(.NReq(NReq), .PtrW(PtrW)) u_rr_arbiter (
    .req      (bus.req),
    .ptr      (rr_ptr_q),
    .grant_c  (grant_c),
    .winner_c (winner_c)
  );

  always_comb begin : winner_fields
    req_op_c = op_e'(bus.op[winner_c]);
    req_id_c = bus.freeId[32'(winner_c)*MW +: MW];
  end

  // The outcome is resolved when the request is accepted so sizeWe can be high during EXEC;
  // allocator state only commits on the EXEC edge.
  always_comb begin : next_state
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    winner_d     = winner_q;
    grant_d      = grant_q;
    op_d         = op_q;
    id_d         = id_q;
    err_d        = err_q;
    from_stack_d = from_stack_q;
    allocs_d     = allocs_q;
    freed_top_d  = freed_top_q;
    in_use_d     = in_use_q;
    stack_d      = stack_q;
    ack_d        = '0;
    ack_id_d     = '0;
    error_d      = 1'b0;
    size_we_d    = 1'b0;
    size_addr_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          state_d      = ST_EXEC;
          winner_d     = winner_c;
          grant_d      = grant_c;
          op_d         = req_op_c;
          from_stack_d = 1'b0;
          if (req_op_c == OP_ALLOC) begin
            if (freed_top_q != '0) begin
              id_d         = stack_q[IdxW'(freed_top_q - MW'(1))];
              err_d        = 1'b0;
              from_stack_d = 1'b1;
            end else if (allocs_q < MW'(NArrays)) begin
              id_d  = allocs_q;
              err_d = 1'b0;
            end else begin
              id_d  = '0;
              err_d = 1'b1;
            end
            size_we_d   = !err_d;
            size_addr_d = err_d ? '0 : id_d;
          end else begin
            id_d  = req_id_c;
            err_d = !((req_id_c < allocs_q) && in_use_q[IdxW'(req_id_c)]);
          end
        end
      end
      ST_EXEC: begin
        state_d = ST_DONE;
        if (!err_q) begin
          if (op_q == OP_ALLOC) begin
            in_use_d[IdxW'(id_q)] = 1'b1;
            if (from_stack_q) freed_top_d = freed_top_q - MW'(1);
            else              allocs_d    = allocs_q + MW'(1);
          end else begin
            in_use_d[IdxW'(id_q)]        = 1'b0;
            stack_d[IdxW'(freed_top_q)] = id_q;
            freed_top_d                  = freed_top_q + MW'(1);
          end
        end
        ack_d    = grant_q;
        ack_id_d = id_q;
        error_d  = err_q;
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        rr_ptr_d = (32'(winner_q) == NReq - 1) ? '0 : winner_q + PtrW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin : state_regs
    if (!reset) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      winner_q     <= '0;
      grant_q      <= '0;
      op_q         <= OP_ALLOC;
      id_q         <= '0;
      err_q        <= 1'b0;
      from_stack_q <= 1'b0;
      allocs_q     <= '0;
      freed_top_q  <= '0;
      in_use_q     <= '0;
      ack_q        <= '0;
      ack_id_q     <= '0;
      error_q      <= 1'b0;
      size_we_q    <= 1'b0;
      size_addr_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      winner_q     <= winner_d;
      grant_q      <= grant_d;
      op_q         <= op_d;
      id_q         <= id_d;
      err_q        <= err_d;
      from_stack_q <= from_stack_d;
      allocs_q     <= allocs_d;
      freed_top_q  <= freed_top_d;
      in_use_q     <= in_use_d;
      ack_q        <= ack_d;
      ack_id_q     <= ack_id_d;
      error_q      <= error_d;
      size_we_q    <= size_we_d;
      size_addr_q  <= size_addr_d;
      busy_q       <= busy_d;
    end
  end

  // Freed-id stack contents are don't-care after reset; freedTop guards every read.
  always_ff @(posedge clock) begin : stack_regs
    stack_q <= stack_d;
  end

  assign bus.ack   = ack_q;
  assign bus.ackId = ack_id_q;
  assign bus.error = error_q;
  assign sizeWe    = size_we_q;
  assign sizeAddr  = size_addr_q;
  assign allocs    = allocs_q;
  assign freedTop  = freed_top_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_array_allocator.sv
// Self-checking bench for array_allocator: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a queue-based allocator model.
module tb_array_allocator;

  localparam int unsigned MW = 12;
  localparam int unsigned NR = 4;
  localparam int unsigned NA = 20;

  logic          clk;
  logic          rst_n;
  logic          sizeWe;
  logic [MW-1:0] sizeAddr;
  logic [MW-1:0] allocs;
  logic [MW-1:0] freedTop;
  logic          busy;

  array_allocator_if #(.NReq(NR), .MemoryElementWidth(MW)) bus ();

  array_allocator #(.MemoryElementWidth(MW), .NArrays(NA), .NReq(NR)) dut (
    .clock    (clk),
    .reset    (rst_n),
    .bus      (bus),
    .sizeWe   (sizeWe),
    .sizeAddr (sizeAddr),
    .allocs   (allocs),
    .freedTop (freedTop),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NR-1:0]    pend;
  logic [NR-1:0]    opv;
  logic [NR*MW-1:0] idv;

  // Reference model state
  int          m_allocs;
  int          m_rr;
  logic [MW-1:0] m_stack[$];
  bit [31:0]   m_in_use;

  typedef struct {
    logic       rst_before;
    logic [3:0] new_req;
    logic [3:0] ops;
    logic [47:0] ids;
    int         w;
    int         id;
    logic       err;
    logic       we;
    int         al;
    int         ft;
    bit         chk_id;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(input logic rb, input logic [3:0] nr, input logic [3:0] ops,
                              input logic [11:0] fid, input int w, input int id, input logic err,
                              input logic we, input int al, input int ft, input bit ci);
    vec_t v;
    v.rst_before = rb; v.new_req = nr; v.ops = ops; v.ids = {4{fid}};
    v.w = w; v.id = id; v.err = err; v.we = we; v.al = al; v.ft = ft; v.chk_id = ci;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    bus.req    = pend;
    bus.op     = opv;
    bus.freeId = idv;
  endtask

  task automatic do_reset();
    pend = '0;
    drive();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    m_allocs = 0;
    m_rr     = 0;
    m_stack.delete();
    m_in_use = '0;
  endtask

  task automatic raise(input int r);
    pend[r] = 1'b1;
    opv[r]  = ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0;
    idv[r*MW +: MW] = MW'($urandom_range(0, m_allocs + 2));
  endtask

  // Model: first pending requester from the rotating start, LIFO reuse then fresh ids.
  task automatic model_step(output int w, output int id, output logic err, output logic we,
                            output bit chk);
    int fid;
    w = -1;
    for (int k = 0; k < int'(NR); k++) begin
      int j;
      j = (m_rr + k) % int'(NR);
      if (w < 0 && pend[j]) w = j;
    end
    err = 1'b0; we = 1'b0; chk = 1'b1; id = 0;
    if (opv[w] == 1'b0) begin
      if (m_stack.size() > 0) begin
        id = int'(m_stack.pop_back()); we = 1'b1; m_in_use[id] = 1'b1;
      end else if (m_allocs < int'(NA)) begin
        id = m_allocs; m_allocs++; we = 1'b1; m_in_use[id] = 1'b1;
      end else begin
        err = 1'b1;
      end
    end else begin
      fid = int'(idv[w*MW +: MW]);
      id  = fid;
      if (fid >= m_allocs || !m_in_use[fid]) begin
        err = 1'b1; chk = 1'b0;
      end else begin
        m_in_use[fid] = 1'b0;
        m_stack.push_back(MW'(fid));
      end
    end
    m_rr = (w + 1) % int'(NR);
  endtask

  // One served request: called at a negedge in IDLE with bus.req already driven.
  task automatic round(input int w, input int id, input logic err, input logic we,
                       input int al, input int ft, input bit chk_id, input string tag);
    logic [NR-1:0] exp_ack;
    exp_ack = NR'(1 << w);
    @(negedge clk);
    check({tag, ".exec_busy"}, 32'(busy), 32'd1);
    check({tag, ".exec_we"}, 32'(sizeWe), 32'(we));
    check({tag, ".exec_addr"}, 32'(sizeAddr), we ? 32'(id) : 32'd0);
    check({tag, ".exec_ack"}, 32'(bus.ack), 32'd0);
    check({tag, ".exec_ackid"}, 32'(bus.ackId), 32'd0);
    opv[w] = 1'($urandom_range(0, 1));
    idv[w*MW +: MW] = MW'($urandom);
    drive();
    @(negedge clk);
    check({tag, ".done_ack"}, 32'(bus.ack), 32'(exp_ack));
    if (chk_id) check({tag, ".done_ackid"}, 32'(bus.ackId), 32'(id));
    check({tag, ".done_err"}, 32'(bus.error), 32'(err));
    check({tag, ".done_we"}, 32'(sizeWe), 32'd0);
    pend[w] = 1'b0;
    drive();
    @(negedge clk);
    check({tag, ".idle_ack"}, 32'(bus.ack), 32'd0);
    check({tag, ".idle_busy"}, 32'(busy), 32'd0);
    check({tag, ".idle_err"}, 32'(bus.error), 32'd0);
    check({tag, ".allocs"}, 32'(allocs), 32'(al));
    check({tag, ".freedtop"}, 32'(freedTop), 32'(ft));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int w, id;
    logic err, we;
    bit chk;
    rst_n = 1'b0;
    pend  = '0;
    opv   = '0;
    idv   = '0;
    drive();

    // Three allocs, free/realloc, double free and out-of-range free
    tbl[0]  = mk(0, 4'b0001, 4'b0000, 12'd0, 0, 0, 0, 1, 1, 0, 1);
    tbl[1]  = mk(0, 4'b0001, 4'b0000, 12'd0, 0, 1, 0, 1, 2, 0, 1);
    tbl[2]  = mk(0, 4'b0001, 4'b0000, 12'd0, 0, 2, 0, 1, 3, 0, 1);
    tbl[3]  = mk(0, 4'b0001, 4'b0001, 12'd1, 0, 1, 0, 0, 3, 1, 1);
    tbl[4]  = mk(0, 4'b0001, 4'b0000, 12'd0, 0, 1, 0, 1, 3, 0, 1);
    tbl[5]  = mk(0, 4'b0001, 4'b0001, 12'd1, 0, 1, 0, 0, 3, 1, 1);
    tbl[6]  = mk(0, 4'b0001, 4'b0001, 12'd1, 0, 1, 1, 0, 3, 1, 0);
    tbl[7]  = mk(0, 4'b0001, 4'b0001, 12'd7, 0, 7, 1, 0, 3, 1, 0);
    tbl[8]  = mk(0, 4'b0001, 4'b0000, 12'd0, 0, 1, 0, 1, 3, 0, 1);
    // All-four burst, a round ending on requester 2, then another burst
    tbl[9]  = mk(1, 4'b1111, 4'b0000, 12'd0, 0, 0, 0, 1, 1, 0, 1);
    tbl[10] = mk(0, 4'b0000, 4'b0000, 12'd0, 1, 1, 0, 1, 2, 0, 1);
    tbl[11] = mk(0, 4'b0000, 4'b0000, 12'd0, 2, 2, 0, 1, 3, 0, 1);
    tbl[12] = mk(0, 4'b0000, 4'b0000, 12'd0, 3, 3, 0, 1, 4, 0, 1);
    tbl[13] = mk(0, 4'b0111, 4'b0000, 12'd0, 0, 4, 0, 1, 5, 0, 1);
    tbl[14] = mk(0, 4'b0000, 4'b0000, 12'd0, 1, 5, 0, 1, 6, 0, 1);
    tbl[15] = mk(0, 4'b0000, 4'b0000, 12'd0, 2, 6, 0, 1, 7, 0, 1);
    tbl[16] = mk(0, 4'b1111, 4'b0000, 12'd0, 3, 7, 0, 1, 8, 0, 1);
    tbl[17] = mk(0, 4'b0000, 4'b0000, 12'd0, 0, 8, 0, 1, 9, 0, 1);
    tbl[18] = mk(0, 4'b0000, 4'b0000, 12'd0, 1, 9, 0, 1, 10, 0, 1);
    tbl[19] = mk(0, 4'b0000, 4'b0000, 12'd0, 2, 10, 0, 1, 11, 0, 1);

    do_reset();
    check("rst.ack", 32'(bus.ack), 32'd0);
    check("rst.ackid", 32'(bus.ackId), 32'd0);
    check("rst.error", 32'(bus.error), 32'd0);
    check("rst.sizewe", 32'(sizeWe), 32'd0);
    check("rst.sizeaddr", 32'(sizeAddr), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.allocs", 32'(allocs), 32'd0);
    check("rst.freedtop", 32'(freedTop), 32'd0);

    for (int i = 0; i < 20; i++) begin
      if (tbl[i].rst_before) do_reset();
      for (int r = 0; r < int'(NR); r++) begin
        if (tbl[i].new_req[r]) begin
          pend[r] = 1'b1;
          opv[r]  = tbl[i].ops[r];
          idv[r*MW +: MW] = tbl[i].ids[r*MW +: MW];
        end
      end
      drive();
      round(tbl[i].w, tbl[i].id, tbl[i].err, tbl[i].we, tbl[i].al, tbl[i].ft,
            tbl[i].chk_id, $sformatf("vec%0d", i));
    end

    // Exhaust the id space, then one more alloc must fail
    do_reset();
    for (int i = 0; i <= int'(NA); i++) begin
      pend[0] = 1'b1;
      opv[0]  = 1'b0;
      drive();
      if (i < int'(NA)) round(0, i, 1'b0, 1'b1, i + 1, 0, 1'b1, $sformatf("fill%0d", i));
      else              round(0, 0, 1'b1, 1'b0, int'(NA), 0, 1'b1, "overflow");
    end

    // Reset while an alloc is in EXEC
    do_reset();
    pend[0] = 1'b1;
    opv[0]  = 1'b0;
    drive();
    @(negedge clk);
    check("midrst.exec_busy", 32'(busy), 32'd1);
    check("midrst.exec_we", 32'(sizeWe), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst.ack", 32'(bus.ack), 32'd0);
    check("midrst.sizewe", 32'(sizeWe), 32'd0);
    check("midrst.allocs", 32'(allocs), 32'd0);
    check("midrst.busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    pend  = '0;
    drive();
    @(negedge clk);
    check("midrst.after_ack", 32'(bus.ack), 32'd0);
    pend[0] = 1'b1;
    opv[0]  = 1'b0;
    drive();
    round(0, 0, 1'b0, 1'b1, 1, 0, 1'b1, "midrst.realloc");

    // Randomized mixed traffic against the model
    do_reset();
    for (int n = 0; n < 250; n++) begin
      for (int r = 0; r < int'(NR); r++)
        if (!pend[r] && $urandom_range(0, 1) == 1) raise(r);
      if (pend == '0) raise(int'($urandom_range(0, NR - 1)));
      drive();
      model_step(w, id, err, we, chk);
      round(w, id, err, we, m_allocs, m_stack.size(), chk, $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
